serial_stack_unloader: RTL and testbench

// - Read-side controller for a bit-serial LIFO stack whose top bit is always visible at its serial output.
// - On a start request it drives len pop cycles and samples the stack's top bit on each pop.
// - It assembles the popped bits into a parallel word and offers that word on a valid/ready handshake.
// - Sits between the unary shift MAC's bit stacks and the downstream parallel accumulate/writeback logic.

---
 rtl/serial_stack_unloader_if.sv | 25 ++
 rtl/serial_stack_unloader.sv | 87 ++++++++
 tb/tb_serial_stack_unloader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_stack_unloader_if.sv
// Handshake bundle between the serial stack unloader, its bit-serial stack and the parallel consumer.
// master = unloader side, slave = stack/consumer side.
interface serial_stack_unloader_if #(
    parameter int NUM_BITS = 16,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
);
    logic                start;
    logic [CNT_W-1:0]    len;
    logic                busy;
    logic                stk_bit;
    logic                stk_pop;
    logic [NUM_BITS-1:0] word_out;
    logic                word_valid;
    logic                word_ready;

    modport master (
        input  start, len, stk_bit, word_ready,
        output busy, stk_pop, word_out, word_valid
    );

    modport slave (
        output start, len, stk_bit, word_ready,
        input  busy, stk_pop, word_out, word_valid
    );
endinterface

// File: rtl/serial_stack_unloader.sv
// Pops len bits off a bit-serial LIFO and presents them as a parallel word on a valid/ready handshake.
// Optional macro SSU_RESTORE_ORDER_EN: place bits in original push order instead of pop order.
module serial_stack_unloader #(
    parameter int NUM_BITS = 16,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input logic                     clk,
    input logic                     reset_n,
    serial_stack_unloader_if.master bus
);
    typedef enum logic [1:0] {IDLE, POP, HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(NUM_BITS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] word_q, word_d;
    logic                busy_q, busy_d;
    logic                stk_pop_q, stk_pop_d;
    logic                word_valid_q, word_valid_d;
    logic [CNT_W-1:0]    len_clamped;
    logic [CNT_W-1:0]    map_idx;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        word_d      = word_q;
        len_clamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
`ifdef SSU_RESTORE_ORDER_EN
        map_idx     = len_q - idx_q - CNT_W'(1);
`else
        map_idx     = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    word_d  = '0;
                    idx_d   = '0;
                    len_d   = len_clamped;
                    state_d = (len_clamped == '0) ? HOLD : POP;
                end
            end
            POP: begin
                for (int k = 0; k < NUM_BITS; k++) begin
                    if (map_idx == CNT_W'(k)) word_d[k] = bus.stk_bit;
                end
                idx_d = idx_q + CNT_W'(1);
                if (idx_q == len_q - CNT_W'(1)) state_d = HOLD;
            end
            HOLD: begin
                if (bus.word_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered decodes of the next state so they line up with state_q.
        busy_d       = (state_d != IDLE);
        stk_pop_d    = (state_d == POP);
        word_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            busy_q       <= 1'b0;
            stk_pop_q    <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            stk_pop_q    <= stk_pop_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.stk_pop    = stk_pop_q;
    assign bus.word_out   = word_q;
    assign bus.word_valid = word_valid_q;
endmodule

// File: tb/tb_serial_stack_unloader.sv
// Directed bench for serial_stack_unloader paired with a 16-deep bit-serial stack model.
module tb_serial_stack_unloader;
    localparam int NB = 16;
    localparam int CW = $clog2(NB + 1);

`ifdef SSU_RESTORE_ORDER_EN
    localparam logic [15:0] E_BASIC = 16'h0003, E_BP = 16'h0003, E_MID = 16'h0009,
                            E_CLAMP = 16'hC3A5, E_RST = 16'h0023;
`else
    localparam logic [15:0] E_BASIC = 16'h000C, E_BP = 16'h0006, E_MID = 16'h0012,
                            E_CLAMP = 16'hA5C3, E_RST = 16'h0031;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    serial_stack_unloader_if #(.NUM_BITS(NB), .CNT_W(CW)) bus ();

    serial_stack_unloader #(.NUM_BITS(NB), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stack model: bit 0 is the top (most recently pushed) bit.
    logic [NB-1:0] stk = '0;
    logic          push_en = 1'b0, push_bit = 1'b0, ld_en = 1'b0;
    logic [NB-1:0] ld_val = '0;
    int            pop_cnt = 0;

    assign bus.stk_bit = stk[0];

    always @(posedge clk) begin
        if (bus.stk_pop) begin
            stk     <= stk >> 1;
            pop_cnt <= pop_cnt + 1;
        end else if (ld_en) begin
            stk <= ld_val;
        end else if (push_en) begin
            stk <= {stk[NB-2:0], push_bit};
        end
    end

    int errors = 0;
    int checks = 0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b);
        push_bit = b;
        push_en  = 1'b1;
        step();
        push_en  = 1'b0;
    endtask

    task automatic load(input logic [NB-1:0] v);
        ld_val = v;
        ld_en  = 1'b1;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic kick(input logic [CW-1:0] l);
        bus.len   = l;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && bus.word_valid !== 1'b1; i++) step();
        chk(tag, 32'(bus.word_valid), 32'd1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.word_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pop", 32'(bus.stk_pop), 32'd0);
        chk("rst_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word", 32'(bus.word_out), 32'h0);
        reset_n = 1'b1;
        step();

        // Basic: push 1,1,0,0 then unload 4
        push(1'b1); push(1'b1); push(1'b0); push(1'b0);
        base = pop_cnt;
        kick(CW'(4));
        chk("basic_busy", 32'(bus.busy), 32'd1);
        wait_valid("basic_valid");
        chk("basic_pops", 32'(pop_cnt - base), 32'd4);
        chk("basic_word", 32'(bus.word_out), 32'(E_BASIC));
        step();
        chk("basic_valid_1cyc", 32'(bus.word_valid), 32'd0);
        chk("basic_idle", 32'(bus.busy), 32'd0);

        // Backpressure: len=3, consumer stalls 5 cycles
        load('0);
        push(1'b1); push(1'b1); push(1'b0);
        bus.word_ready = 1'b0;
        base = pop_cnt;
        kick(CW'(3));
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(bus.word_valid), 32'd1);
            chk("bp_hold_word", 32'(bus.word_out), 32'(E_BP));
            chk("bp_no_pop", 32'(bus.stk_pop), 32'd0);
            step();
        end
        chk("bp_pops", 32'(pop_cnt - base), 32'd3);
        bus.word_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(bus.word_valid), 32'd0);
        chk("bp_release_busy", 32'(bus.busy), 32'd0);

        // start / len disturbance mid-POP
        load('0);
        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        push(1'b0); push(1'b0); push(1'b1); push(1'b0);
        base = pop_cnt;
        kick(CW'(5));
        step();
        bus.start = 1'b1;
        bus.len   = CW'(2);
        step();
        bus.start = 1'b0;
        bus.len   = CW'(9);
        step();
        bus.len   = '0;
        wait_valid("mid_valid");
        chk("mid_pops", 32'(pop_cnt - base), 32'd5);
        chk("mid_word", 32'(bus.word_out), 32'(E_MID));
        step();
        chk("mid_idle", 32'(bus.busy), 32'd0);

        // len == 0: no pops, zero word, valid next cycle
        load(16'hFFFF);
        base = pop_cnt;
        kick('0);
        chk("len0_valid", 32'(bus.word_valid), 32'd1);
        chk("len0_word", 32'(bus.word_out), 32'h0);
        chk("len0_pops", 32'(pop_cnt - base), 32'd0);
        step();
        chk("len0_idle", 32'(bus.busy), 32'd0);

        // len == 20 clamps to 16 pops
        load(16'hA5C3);
        base = pop_cnt;
        kick(CW'(20));
        wait_valid("clamp_valid");
        chk("clamp_pops", 32'(pop_cnt - base), 32'd16);
        chk("clamp_word", 32'(bus.word_out), 32'(E_CLAMP));
        step();

        // Reset after 2 of 8 pops, then unload the remaining 6
        load(16'h00C6);
        base = pop_cnt;
        kick(CW'(8));
        for (int i = 0; i < 20 && (pop_cnt - base) < 2; i++) step();
        chk("rstmid_two_pops", 32'(pop_cnt - base), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_pop", 32'(bus.stk_pop), 32'd0);
        chk("rstmid_valid", 32'(bus.word_valid), 32'd0);
        chk("rstmid_word", 32'(bus.word_out), 32'h0);
        step();
        chk("rstmid_no_extra_pop", 32'(pop_cnt - base), 32'd2);
        reset_n = 1'b1;
        step();
        base = pop_cnt;
        kick(CW'(6));
        wait_valid("rstmid_valid2");
        chk("rstmid_pops2", 32'(pop_cnt - base), 32'd6);
        chk("rstmid_word2", 32'(bus.word_out), 32'(E_RST));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
